// File: rtl/fetch_wb.sv
// fetch_wb: instruction-fetch Wishbone master with prefetch FIFO and redirect flush
module fetch_wb #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(FIFO_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, BUS, DROP} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, adr_q, adr_d, rpc;
  logic cyc_q, cyc_d, push, pop;
  logic [31:0] fd_q [FIFO_DEPTH];
  logic [31:0] fp_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  assign rpc = redirect_pc & ~32'h3;
  assign pop = instr_valid & instr_ready;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    adr_d = adr_q;
    cyc_d = cyc_q;
    push = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d = redirect_valid ? rpc : pc_q;
        if (!redirect_valid && cnt_q < DEPTH) begin
          state_d = BUS;
          cyc_d = 1'b1;
          adr_d = pc_q;
        end
      end
      BUS: begin
        if (wbm_ack_i && redirect_valid) begin
          pc_d = rpc;
          adr_d = rpc;
        end else if (wbm_ack_i) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
          adr_d = pc_q + 32'd4;
          cyc_d = cnt_q < LAST;
          state_d = cnt_q < LAST ? BUS : IDLE;
        end else if (redirect_valid) begin
          pc_d = rpc;
          state_d = DROP;
        end
      end
      DROP: begin
        pc_d = redirect_valid ? rpc : pc_q;
        if (wbm_ack_i) begin
          state_d = BUS;
          adr_d = pc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q <= RESET_PC & ~32'h3;
      adr_q <= '0;
      cyc_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      adr_q <= adr_d;
      cyc_q <= cyc_d;
      if (redirect_valid) begin
        rd_q <= '0;
        wr_q <= '0;
        cnt_q <= '0;
      end else begin
        if (push) begin
          fd_q[wr_q] <= wbm_dat_i;
          fp_q[wr_q] <= pc_q;
          wr_q <= wr_q + AW'(1);
        end
        if (pop) rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  assign instr_valid = cnt_q != '0;
  assign instr_data = fd_q[rd_q];
  assign instr_pc = fp_q[rd_q];
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_adr_o = adr_q;
  assign wbm_we_o = 1'b0;
  assign wbm_sel_o = 4'hF;
endmodule

// File: tb/tb_fetch_wb.sv
// tb_fetch_wb: scoreboard bench for fetch_wb with a random-latency ROM slave
module tb_fetch_wb;
  logic clk = 0, resetn = 0, redirect_valid = 0, instr_ready = 0, wbm_ack_i = 0;
  logic [31:0] redirect_pc = 0, wbm_dat_i = 0, instr_data, instr_pc, wbm_adr_o;
  logic instr_valid, wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0] wbm_sel_o;
  int n_chk = 0, n_fail = 0, hs_cnt = 0, dmax = 0, dly = 0;
  logic hold = 0, force_ack = 0, stray_ack = 0, mon_en = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ack_log[$];
  fetch_wb dut (
    .clk(clk), .resetn(resetn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  function automatic logic [31:0] logged(input int i);
    return ack_log.size() > i ? ack_log[i] : 32'h1;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic load(input logic [31:0] a);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back((a & ~32'h3) + 32'(i * 4));
  endtask
  task automatic do_reset();
    @(posedge clk); #2 resetn = 0;
    @(posedge clk); load(32'h0); ack_log.delete();
    #2 resetn = 1;
  endtask
  task automatic redirect_to(input logic [31:0] a);
    @(posedge clk); #2 redirect_valid = 1; redirect_pc = a;
    @(posedge clk); load(a);
    #2 redirect_valid = 0; redirect_pc = $urandom;
  endtask
  task automatic wait_cyc();
    int n = 0;
    @(negedge clk);
    while (!wbm_cyc_o && n < 30) begin @(negedge clk); n++; end
    chk("wait_cyc", 32'(wbm_cyc_o), 1);
  endtask
  task automatic wait_log(input int k);
    int n = 0;
    while (ack_log.size() < k && n < 40) begin @(negedge clk); n++; end
    chk("wait_ack_log", 32'(ack_log.size() >= k), 1);
  endtask
  task automatic quiesce_slave();
    hold = 1;
    repeat (2) @(posedge clk);
    wait_cyc();
  endtask
  // ROM slave: acks at least one cycle after stb, never on consecutive cycles
  initial begin
    forever begin
      @(posedge clk); #1;
      if (wbm_ack_i) wbm_ack_i = 0;
      else if (stray_ack) begin wbm_ack_i = 1; wbm_dat_i = $urandom; end
      else if (wbm_cyc_o && wbm_stb_o && (force_ack || (!hold && dly == 0))) begin
        wbm_ack_i = 1;
        wbm_dat_i = rom(wbm_adr_o);
        ack_log.push_back(wbm_adr_o);
        dly = $urandom_range(0, dmax);
      end else if (wbm_cyc_o && !hold && dly > 0) dly--;
    end
  end
  // monitor: bus invariants, stall stability, scoreboard of consumed words
  initial begin
    logic stall = 0;
    logic [31:0] st_pc = 0, st_data = 0, e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (wbm_cyc_o) begin
          chk("stb_eq_cyc", 32'(wbm_stb_o), 1);
          chk("adr_align", 32'(wbm_adr_o[1:0]), 0);
          chk("we_sel", {27'd0, wbm_we_o, wbm_sel_o}, 32'hF);
        end
        if (stall) begin
          chk("stall_valid", 32'(instr_valid), 1);
          chk("stall_pc", instr_pc, st_pc);
          chk("stall_data", instr_data, st_data);
        end
        if (instr_valid && instr_ready) begin
          hs_cnt++;
          chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e);
            chk("instr_data", instr_data, rom(e));
          end
        end
        stall = instr_valid && !instr_ready && resetn && !redirect_valid;
        st_pc = instr_pc;
        st_data = instr_data;
      end
    end
  end
  initial begin
    int h0;
    logic [31:0] old;
    repeat (2) @(posedge clk);
    instr_ready = 1;
    do_reset();
    @(negedge clk);
    chk("rst_cyc", 32'(wbm_cyc_o), 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_valid", 32'(instr_valid), 0);
    mon_en = 1;
    repeat (10) @(posedge clk);
    h0 = hs_cnt;
    repeat (40) @(posedge clk);
    chk("throughput", 32'(hs_cnt - h0), 20);
    #2 instr_ready = 0;
    do_reset();
    repeat (30) @(negedge clk);
    chk("stall_reads", 32'(ack_log.size()), 2);
    chk("stall_adr0", logged(0), 32'h0);
    chk("stall_adr1", logged(1), 32'h4);
    chk("stall_cyc_low", 32'(wbm_cyc_o), 0);
    chk("stall_head_pc", instr_pc, 32'h0);
    @(posedge clk); #2 instr_ready = 1; ack_log.delete();
    wait_log(1);
    chk("resume_adr", logged(0), 32'h8);
    quiesce_slave();
    old = wbm_adr_o;
    redirect_to(32'h100);
    @(negedge clk);
    chk("drop_cyc_held", 32'(wbm_cyc_o), 1);
    chk("drop_adr_held", wbm_adr_o, old);
    ack_log.delete(); hold = 0;
    wait_log(2);
    chk("drop_acked", logged(0), old);
    chk("redir_adr_100", logged(1), 32'h100);
    repeat (10) @(posedge clk);
    quiesce_slave();
    old = wbm_adr_o;
    ack_log.delete();
    @(posedge clk); #2 force_ack = 1;
    redirect_to(32'h203);
    force_ack = 0; hold = 0;
    wait_log(2);
    chk("ack_redir_old", logged(0), old);
    chk("ack_redir_adr", logged(1), 32'h200);
    repeat (10) @(posedge clk);
    quiesce_slave();
    @(posedge clk); #2 resetn = 0; stray_ack = 1;
    @(posedge clk); load(32'h0); ack_log.delete();
    #2 resetn = 1; stray_ack = 0;
    @(negedge clk);
    chk("midrst_cyc", 32'(wbm_cyc_o), 0);
    chk("midrst_stb", 32'(wbm_stb_o), 0);
    chk("midrst_valid", 32'(instr_valid), 0);
    hold = 0;
    wait_log(1);
    chk("midrst_refetch", logged(0), 32'h0);
    repeat (10) @(posedge clk);
    h0 = hs_cnt;
    redirect_to(32'hFFFF_FFF8);
    repeat (20) @(posedge clk);
    chk("wrap_words", 32'(hs_cnt - h0 >= 4), 1);
    dmax = 2;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 3) redirect_to($urandom);
      else begin
        @(posedge clk); #2 instr_ready = $urandom_range(0, 9) < 7;
      end
    end
    instr_ready = 1;
    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
